// File: rtl/regfile_scoreboard.sv
// Register file with optional hardwired-zero r0, write-to-read bypass and a
// per-register busy scoreboard (claim / release-by-write / flush) used by the
// issue stage to track destinations of long-latency operations.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_busy_1,
    output logic              rd_busy_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              claim_ok,
    input  logic              flush,
    output logic [ADDR_W:0]   busy_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [ADDR_W:0]     r_busyCount;

    logic [NUM_REGS-1:0] w_busyNext;
    logic [ADDR_W:0]     w_busyCountNext;
    logic                w_wrValid;
    logic                w_claimSet;

    // A write to the hardwired-zero register is dropped entirely, so it
    // neither updates storage, releases a busy bit, nor bypasses to a reader.
    assign w_wrValid = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    // A claim is accepted if the target is free, or is being written this
    // cycle (the new pending write supersedes); flush always blocks claims.
    assign claim_ok = claim_en
                      && (!r_busy[claim_addr] || (wr_en && (wr_addr == claim_addr)))
                      && !flush;

    // An accepted claim to r0 is acknowledged but must not mark it busy.
    assign w_claimSet = claim_ok && !((ZERO_REG != 0) && (claim_addr == '0));

    // Next busy vector: write releases, claim sets (claim wins on the same
    // register), flush clears everything, r0 is never busy.
    always_comb begin
        w_busyNext = r_busy;
        if (flush) begin
            w_busyNext = '0;
        end else begin
            if (w_wrValid) begin
                w_busyNext[wr_addr] = 1'b0;
            end
            if (w_claimSet) begin
                w_busyNext[claim_addr] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            w_busyNext[0] = 1'b0;
        end
    end

    // Population count of the post-edge busy vector, registered below so the
    // count always matches the busy bits visible in the same cycle.
    always_comb begin
        w_busyCountNext = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_busyCountNext = w_busyCountNext + (ADDR_W + 1)'(w_busyNext[i]);
        end
    end

    // Register storage; reset clears every entry so stale data never leaks.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wrValid && (wr_addr == ADDR_W'(i))) begin
                    r_mem[i] <= wr_data;
                end
            end
        end
    end

    // Busy scoreboard and its count; reset discards any pending claims.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            r_busy      <= '0;
            r_busyCount <= '0;
        end else begin
            r_busy      <= w_busyNext;
            r_busyCount <= w_busyCountNext;
        end
    end

    assign busy_count = r_busyCount;

    // Read port 1: storage, then same-cycle write forwarding, then the r0 rule.
    always_comb begin
        rd_data_1 = r_mem[rd_addr_1];
        rd_busy_1 = r_busy[rd_addr_1];
        if ((BYPASS != 0) && w_wrValid && (wr_addr == rd_addr_1)) begin
            rd_data_1 = wr_data;
            rd_busy_1 = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd_addr_1 == '0)) begin
            rd_data_1 = '0;
            rd_busy_1 = 1'b0;
        end
    end

    // Read port 2: identical resolution order to port 1.
    always_comb begin
        rd_data_2 = r_mem[rd_addr_2];
        rd_busy_2 = r_busy[rd_addr_2];
        if ((BYPASS != 0) && w_wrValid && (wr_addr == rd_addr_2)) begin
            rd_data_2 = wr_data;
            rd_busy_2 = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd_addr_2 == '0)) begin
            rd_data_2 = '0;
            rd_busy_2 = 1'b0;
        end
    end

endmodule
